// File: rtl/riscv_pkg.sv
// riscv_pkg
// Definitions shared by the riscv_parser / riscv_merger pair.
// - merger_state_t : packet-ownership state of the merger arbiter.
// - ETH_TYPE_IPV4, IPPROT_UDP, RISCV_PORT, CONTROL_PORT : header match
//   constants, kept here so the parser and merger use one definition.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } merger_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPPROT_UDP    = 8'h11;
    localparam logic [15:0] RISCV_PORT    = 16'h1234;
    localparam logic [15:0] CONTROL_PORT  = 16'hF1F2;

endpackage

// File: rtl/riscv_merger_if.sv
// riscv_merger_if
// One AXI-Stream link (tdata/tkeep/tuser/tvalid/tlast/tready).
// - master : drives payload and tvalid, receives tready.
// - slave  : receives payload and tvalid, drives tready.
interface riscv_merger_if #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 128
);

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/riscv_merger_arb.sv
// riscv_merger_arb
// Packet-boundary arbiter for the 2:1 merger.
// Ports:
//   clk, aresetn          clock and asynchronous active-low reset
//   s0_tvalid, s1_tvalid  requests from the two inputs
//   accept                a beat of the selected input is taken this cycle
//   accept_last           the accepted beat carries tlast
//   grant                 some input owns (or may take) the output this cycle
//   sel                   which input is granted (0 or 1)
module riscv_merger_arb
    import riscv_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic clk,
    input  logic aresetn,
    input  logic s0_tvalid,
    input  logic s1_tvalid,
    input  logic accept,
    input  logic accept_last,
    output logic grant,
    output logic sel
);

    merger_state_t state;
    logic          last_grant;

    // Once locked the owner is fixed regardless of the other input's
    // tvalid, which keeps packets from interleaving.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        case (state)
            LOCK0: begin
                grant = 1'b1;
                sel   = 1'b0;
            end
            LOCK1: begin
                grant = 1'b1;
                sel   = 1'b1;
            end
            default: begin
                if (s0_tvalid && s1_tvalid) begin
                    grant = 1'b1;
                    sel   = (PRIO_MODE == 1) ? 1'b1 : ~last_grant;
                end else if (s0_tvalid) begin
                    grant = 1'b1;
                    sel   = 1'b0;
                end else if (s1_tvalid) begin
                    grant = 1'b1;
                    sel   = 1'b1;
                end
            end
        endcase
    end

    // last_grant resets to 1 so input 0 wins the first tie.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else if (accept) begin
            if (accept_last) begin
                state      <= IDLE;
                last_grant <= sel;
            end else begin
                state <= sel ? LOCK1 : LOCK0;
            end
        end
    end

endmodule

// File: rtl/riscv_merger.sv
// riscv_merger
// Packet-atomic 2:1 AXI-Stream merger placed after riscv_parser.
// Ports:
//   clk, aresetn  clock and asynchronous active-low reset
//   s0_axis       input 0, parser data path (slave)
//   s1_axis       input 1, RISC-V core response stream (slave)
//   m_axis        merged, registered output (master)
//   pkt_cnt0/1    packets forwarded per input, wrapping
module riscv_merger
    import riscv_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PRIO_MODE            = 0,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    riscv_merger_if.slave        s0_axis,
    riscv_merger_if.slave        s1_axis,
    riscv_merger_if.master       m_axis,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1
);

    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    logic                            out_ready;
    logic                            grant;
    logic                            sel;
    logic                            sel_valid;
    logic                            sel_last;
    logic                            accept;

    logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_q;
    logic [KW-1:0]                   tkeep_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic [CNT_WIDTH-1:0]            pkt_cnt0_q;
    logic [CNT_WIDTH-1:0]            pkt_cnt1_q;

    assign out_ready = !tvalid_q || m_axis.tready;
    assign sel_valid = sel ? s1_axis.tvalid : s0_axis.tvalid;
    assign sel_last  = sel ? s1_axis.tlast  : s0_axis.tlast;
    assign accept    = grant && out_ready && sel_valid;

    assign s0_axis.tready = grant && !sel && out_ready;
    assign s1_axis.tready = grant &&  sel && out_ready;

    riscv_merger_arb #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk         (clk),
        .aresetn     (aresetn),
        .s0_tvalid   (s0_axis.tvalid),
        .s1_tvalid   (s1_axis.tvalid),
        .accept      (accept),
        .accept_last (sel_last),
        .grant       (grant),
        .sel         (sel)
    );

    // Output register: loads on accept, drops tvalid once the held beat is
    // consumed with nothing new behind it; payload holds in that case.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (accept) begin
            tdata_q  <= sel ? s1_axis.tdata : s0_axis.tdata;
            tkeep_q  <= sel ? s1_axis.tkeep : s0_axis.tkeep;
            tuser_q  <= sel ? s1_axis.tuser : s0_axis.tuser;
            tlast_q  <= sel_last;
            tvalid_q <= 1'b1;
        end else if (m_axis.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // A packet is counted when its tlast beat is accepted.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else if (accept && sel_last) begin
            if (sel) begin
                pkt_cnt1_q <= pkt_cnt1_q + CNT_WIDTH'(1);
            end else begin
                pkt_cnt0_q <= pkt_cnt0_q + CNT_WIDTH'(1);
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign pkt_cnt0      = pkt_cnt0_q;
    assign pkt_cnt1      = pkt_cnt1_q;

endmodule
